// File: rtl/pc_seq_ctrl_if.sv
// Fetch-side bundle: instruction-memory request/response and the decode handshake.
interface pc_seq_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            ins_valid;
  logic            ins_ready;
  logic [XLEN-1:0] ins_out;
  logic [XLEN-1:0] ins_pc;

  modport master (
    output imem_req, imem_addr, ins_valid, ins_out, ins_pc,
    input  imem_ack, imem_rdata, ins_ready
  );

  modport slave (
    input  imem_req, imem_addr, ins_valid, ins_out, ins_pc,
    output imem_ack, imem_rdata, ins_ready
  );
endinterface

// File: rtl/pc_seq_ctrl.sv
// Fetch sequencer owning the architectural PC: issues instruction-memory requests,
// hands words to decode, and arbitrates sequential advance, redirects and trap entry.
module pc_seq_ctrl #(
  parameter int unsigned XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            ena,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  pc_seq_ctrl_if.master   bus,
  output logic            flush,
  output logic            misalign_exc,
  output logic [XLEN-1:0] misalign_addr,
  output logic [XLEN-1:0] fetch_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;

  logic            aligned_c;
  logic            take_c;
  logic            misal_c;
  logic            handshake_c;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] pc_inc_c;

  // Trap wins over a branch; a misaligned branch target is reported, not taken.
  assign aligned_c   = (redir_pc[1:0] == 2'b00);
  assign take_c      = trap_valid | (redir_valid & aligned_c);
  assign misal_c     = redir_valid & ~trap_valid & ~aligned_c;
  assign target_c    = trap_valid ? (trap_vec & ~XLEN'(3)) : redir_pc;
  assign pc_inc_c    = pc + XLEN'(4);
  assign handshake_c = bus.ins_valid & bus.ins_ready;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= RESET_PC;
      bus.ins_valid <= 1'b0;
      bus.ins_out   <= '0;
      bus.ins_pc    <= '0;
      flush         <= 1'b0;
      misalign_exc  <= 1'b0;
      misalign_addr <= '0;
      fetch_cnt     <= '0;
    end else begin
      flush        <= take_c;
      misalign_exc <= misal_c;
      if (misal_c) begin
        misalign_addr <= redir_pc;
      end
      if (handshake_c) begin
        fetch_cnt <= fetch_cnt + XLEN'(1);
      end
      if (take_c) begin
        pc            <= target_c;
        bus.ins_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!take_c && ena) begin
            state         <= REQ;
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= pc;
          end
        end

        REQ: begin
          if (!bus.imem_req) begin
            // Gap cycle after a redirect that collided with an ack: re-issue at the new pc.
            bus.imem_req <= 1'b1;
            if (take_c) begin
              bus.imem_addr <= target_c;
            end
          end else if (bus.imem_ack) begin
            bus.imem_req <= 1'b0;
            if (take_c) begin
              bus.imem_addr <= target_c;
            end else begin
              bus.ins_out   <= bus.imem_rdata;
              bus.ins_pc    <= pc;
              bus.ins_valid <= 1'b1;
              pc            <= pc_inc_c;
              state         <= HOLD;
            end
          end else if (take_c) begin
            state <= DROP;
          end
        end

        HOLD: begin
          if (take_c || handshake_c) begin
            bus.ins_valid <= 1'b0;
            state         <= ena ? REQ : IDLE;
            bus.imem_req  <= ena;
            bus.imem_addr <= take_c ? target_c : pc;
          end
        end

        DROP: begin
          // Wrong-path request stays on the bus until the memory answers.
          if (bus.imem_ack) begin
            state         <= ena ? REQ : IDLE;
            bus.imem_req  <= ena;
            bus.imem_addr <= take_c ? target_c : pc;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: transaction-level fetch model checked every cycle plus directed literals.
module tb_pc_seq_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        nreset;
  logic        ena;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        trap_valid;
  logic [31:0] trap_vec;
  logic        flush;
  logic        misalign_exc;
  logic [31:0] misalign_addr;
  logic [31:0] fetch_cnt;

  pc_seq_ctrl_if #(.XLEN(32)) bus ();

  pc_seq_ctrl #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .nreset       (nreset),
    .ena          (ena),
    .redir_valid  (redir_valid),
    .redir_pc     (redir_pc),
    .trap_valid   (trap_valid),
    .trap_vec     (trap_vec),
    .bus          (bus.master),
    .flush        (flush),
    .misalign_exc (misalign_exc),
    .misalign_addr(misalign_addr),
    .fetch_cnt    (fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  // Memory: acks a request after mem_lat waiting cycles; stray_req injects an unsolicited ack.
  int mem_lat = 1;
  int mem_cnt = 0;
  int stray_req = 0;
  int stray_done = 0;

  always @(posedge clk) begin
    #1;
    if (bus.imem_ack === 1'b1) begin
      bus.imem_ack = 1'b0;
      mem_cnt      = 0;
    end else begin
      bus.imem_ack = 1'b0;
      if (stray_req != stray_done) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        stray_done     = stray_req;
      end else if (bus.imem_req === 1'b1) begin
        if (mem_cnt >= mem_lat) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem_word(bus.imem_addr);
        end else begin
          mem_cnt++;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  // Fetch model state
  bit          model_on = 1'b0;
  logic [31:0] model_pc;
  logic [31:0] live_addr;
  bit          req_live;
  bit          exp_iv;
  logic [31:0] exp_pc, exp_out;
  bit          exp_flush, exp_mis;
  logic [31:0] exp_mis_addr;
  logic [31:0] exp_cnt;
  bit          prev_req, prev_ack;
  logic [31:0] prev_addr;
  logic [31:0] req_log[$];
  int          flush_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon_step();
    bit          newreq;
    bit          acc, mis;
    logic [31:0] tgt;
    newreq = (bus.imem_req === 1'b1) && (!prev_req || prev_ack);
    if (model_on) begin
      chk("ins_valid", 32'(bus.ins_valid), 32'(exp_iv));
      if (exp_iv) begin
        chk("ins_pc", bus.ins_pc, exp_pc);
        chk("ins_out", bus.ins_out, exp_out);
        chk("req_in_hold", 32'(bus.imem_req), 32'd0);
      end
      chk("flush", 32'(flush), 32'(exp_flush));
      chk("misalign_exc", 32'(misalign_exc), 32'(exp_mis));
      if (exp_mis) chk("misalign_addr", misalign_addr, exp_mis_addr);
      chk("fetch_cnt", fetch_cnt, exp_cnt);
      if (newreq) begin
        chk("req_addr", bus.imem_addr, model_pc);
        req_log.push_back(bus.imem_addr);
        req_live  = 1'b1;
        live_addr = bus.imem_addr;
      end else if (bus.imem_req === 1'b1) begin
        chk("addr_stable", bus.imem_addr, prev_addr);
      end
    end
    if (flush === 1'b1) flush_seen++;
    prev_req  = (bus.imem_req === 1'b1);
    prev_ack  = (bus.imem_ack === 1'b1);
    prev_addr = bus.imem_addr;

    // Predict the outputs after the coming rising edge
    if (nreset !== 1'b1) begin
      model_on  = 1'b1;
      model_pc  = RST_PC;
      req_live  = 1'b0;
      exp_iv    = 1'b0;
      exp_flush = 1'b0;
      exp_mis   = 1'b0;
      exp_cnt   = 32'd0;
    end else begin
      if (exp_iv && bus.ins_ready) exp_cnt = exp_cnt + 32'd1;
      acc = trap_valid || (redir_valid && redir_pc[1:0] == 2'b00);
      mis = redir_valid && !trap_valid && redir_pc[1:0] != 2'b00;
      tgt = trap_valid ? {trap_vec[31:2], 2'b00} : redir_pc;
      exp_flush = acc;
      exp_mis   = mis;
      if (mis) exp_mis_addr = redir_pc;
      if (acc) begin
        model_pc = tgt;
        req_live = 1'b0;
        exp_iv   = 1'b0;
      end else if (bus.imem_ack === 1'b1 && req_live) begin
        exp_iv   = 1'b1;
        exp_pc   = live_addr;
        exp_out  = bus.imem_rdata;
        model_pc = live_addr + 32'd4;
        req_live = 1'b0;
      end else if (exp_iv && bus.ins_ready) begin
        exp_iv = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon_step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req(output logic [31:0] a);
    int n0;
    bit got;
    n0  = req_log.size();
    got = 1'b0;
    a   = 32'hxxxx_xxxx;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (req_log.size() > n0) begin
        got = 1'b1;
        a   = req_log[req_log.size()-1];
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL wait_req timeout actual=none required=request");
    end
  endtask

  task automatic wait_iv();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.ins_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL wait_iv timeout actual=0 required=1");
    end
  endtask

  initial begin
    logic [31:0] a, b, p, o;
    int f0;
    nreset = 1'b0; ena = 1'b1; redir_valid = 1'b0; redir_pc = '0;
    trap_valid = 1'b0; trap_vec = '0; bus.ins_ready = 1'b1;

    // Reset state and first request timing
    tick(); tick();
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_imem_addr", bus.imem_addr, RST_PC);
    chk("rst_ins_valid", 32'(bus.ins_valid), 32'd0);
    chk("rst_ins_pc", bus.ins_pc, 32'd0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    nreset = 1'b1;
    tick();
    chk("first_req", 32'(bus.imem_req), 32'd1);
    chk("first_addr", bus.imem_addr, RST_PC);

    // Sequential fetch
    for (int i = 0; i < 40; i++) begin
      tick();
      if (exp_cnt >= 32'd3) break;
    end
    chk("fetch_cnt3", fetch_cnt, 32'd3);
    chk("seq_len", 32'(req_log.size() >= 3), 32'd1);
    if (req_log.size() >= 3) begin
      chk("seq0", req_log[0], 32'h100);
      chk("seq1", req_log[1], 32'h104);
      chk("seq2", req_log[2], 32'h108);
    end

    // Decode backpressure in HOLD
    bus.ins_ready = 1'b0;
    wait_iv();
    p = bus.ins_pc; o = bus.ins_out;
    chk("hold_data", o, mem_word(p));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_valid", 32'(bus.ins_valid), 32'd1);
      chk("hold_pc", bus.ins_pc, p);
      chk("hold_out", bus.ins_out, o);
      chk("hold_noreq", 32'(bus.imem_req), 32'd0);
    end
    bus.ins_ready = 1'b1;
    wait_req(a);
    chk("after_hold_addr", a, p + 32'd4);
    chk("after_hold_cnt", fetch_cnt, 32'd4);

    // Redirect while a slow request is outstanding
    mem_lat = 3;
    wait_req(a);
    f0 = flush_seen;
    redir_valid = 1'b1; redir_pc = 32'h0000_2000;
    tick();
    redir_valid = 1'b0;
    chk("drop_flush", 32'(flush), 32'd1);
    chk("drop_req", 32'(bus.imem_req), 32'd1);
    chk("drop_addr", bus.imem_addr, a);
    wait_req(b);
    chk("redir_addr", b, 32'h0000_2000);
    chk("drop_flush_once", 32'(flush_seen), 32'(f0 + 1));

    // Trap and redirect together in HOLD
    mem_lat = 1;
    bus.ins_ready = 1'b0;
    wait_iv();
    f0 = flush_seen;
    trap_valid = 1'b1; trap_vec = 32'h8000_0003;
    redir_valid = 1'b1; redir_pc = 32'h0000_0044;
    tick();
    trap_valid = 1'b0; redir_valid = 1'b0;
    chk("trap_kill", 32'(bus.ins_valid), 32'd0);
    chk("trap_flush", 32'(flush), 32'd1);
    wait_req(a);
    chk("trap_addr", a, 32'h8000_0000);
    chk("trap_flush_once", 32'(flush_seen), 32'(f0 + 1));

    // Misaligned redirect
    wait_iv();
    p = bus.ins_pc;
    redir_valid = 1'b1; redir_pc = 32'h0000_1002;
    tick();
    redir_valid = 1'b0;
    chk("mis_exc", 32'(misalign_exc), 32'd1);
    chk("mis_addr", misalign_addr, 32'h0000_1002);
    chk("mis_noflush", 32'(flush), 32'd0);
    chk("mis_keep_valid", 32'(bus.ins_valid), 32'd1);
    bus.ins_ready = 1'b1;
    wait_req(a);
    chk("mis_next_addr", a, p + 32'd4);

    // PC wrap at the top of the address space
    bus.ins_ready = 1'b0;
    wait_iv();
    redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFC;
    tick();
    redir_valid = 1'b0;
    bus.ins_ready = 1'b1;
    wait_req(a);
    chk("wrap_top", a, 32'hFFFF_FFFC);
    wait_req(b);
    chk("wrap_zero", b, 32'h0000_0000);

    // Reset mid-request, then an unsolicited ack
    mem_lat = 5;
    wait_req(a);
    nreset = 1'b0; ena = 1'b0;
    tick();
    chk("mid_rst_req", 32'(bus.imem_req), 32'd0);
    chk("mid_rst_addr", bus.imem_addr, RST_PC);
    chk("mid_rst_valid", 32'(bus.ins_valid), 32'd0);
    chk("mid_rst_cnt", fetch_cnt, 32'd0);
    nreset = 1'b1;
    tick();
    stray_req++;
    tick(); tick(); tick();
    chk("stray_ignored", 32'(bus.ins_valid), 32'd0);
    chk("stray_noreq", 32'(bus.imem_req), 32'd0);
    mem_lat = 1; ena = 1'b1;
    wait_req(a);
    chk("post_rst_addr", a, RST_PC);
    for (int i = 0; i < 6; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
